// File: rtl/ecb_pkg.sv
// Shared types and constants for the serial ECB XOR datapath.
// The optional ECB_DEC_BLKCNT_EN feature lives in ecb_dec_serial.
package ecb_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ecb_state_e;

    localparam int unsigned ECB_BLOCK_W = 64;

    function automatic int unsigned slices(input int unsigned block_w,
                                           input int unsigned bits_per_cyc);
        return block_w / bits_per_cyc;
    endfunction

endpackage

// File: rtl/ecb_dec_1bit.sv
// Single-bit ECB decrypt cell: plaintext bit is ciphertext bit XOR key bit.
module ecb_dec_1bit (
    input  logic k_i,
    input  logic ct_i,
    output logic pt_o
);

    assign pt_o = ct_i ^ k_i;

endmodule

// File: rtl/ecb_dec_serial.sv
// Serial ECB XOR decryptor: BITS_PER_CYC bits per clock, valid/ready in and out.
// Define ECB_DEC_BLKCNT_EN to add the blk_cnt output counting pt handshakes.
module ecb_dec_serial
    import ecb_pkg::*;
#(
    parameter int unsigned BLOCK_W      = ECB_BLOCK_W,
    parameter int unsigned BITS_PER_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [BLOCK_W-1:0] key_in,
    input  logic               key_we,
    input  logic [BLOCK_W-1:0] ct_data,
    input  logic               ct_valid,
    output logic               ct_ready,
    output logic [BLOCK_W-1:0] pt_data,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic               busy
`ifdef ECB_DEC_BLKCNT_EN
    ,
    output logic [31:0]        blk_cnt
`endif
);

    localparam int unsigned NSLICE = slices(BLOCK_W, BITS_PER_CYC);
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    ecb_state_e         state_q, state_d;
    logic [BLOCK_W-1:0] key_q, key_d;
    logic [BLOCK_W-1:0] wkey_q, wkey_d;
    logic [BLOCK_W-1:0] ct_q, ct_d;
    logic [BLOCK_W-1:0] pt_q, pt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ct_ready_q, ct_ready_d;
    logic               pt_valid_q, pt_valid_d;
    logic               busy_q, busy_d;
`ifdef ECB_DEC_BLKCNT_EN
    logic [31:0]        blk_cnt_q, blk_cnt_d;
`endif

    logic [BITS_PER_CYC-1:0] slice_pt;
    logic [BLOCK_W-1:0]      slice_ext;

    for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_cell
        ecb_dec_1bit u_cell (
            .k_i  (wkey_q[i]),
            .ct_i (ct_q[i]),
            .pt_o (slice_pt[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        key_d     = key_we ? key_in : key_q;
        wkey_d    = wkey_q;
        ct_d      = ct_q;
        pt_d      = pt_q;
        cnt_d     = cnt_q;
        slice_ext = BLOCK_W'(slice_pt);
`ifdef ECB_DEC_BLKCNT_EN
        blk_cnt_d = blk_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (ct_valid) begin
                    ct_d    = ct_data;
                    // Same-cycle key write reaches the accepted block.
                    wkey_d  = key_we ? key_in : key_q;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Slices enter from the MSB so the first slice ends at the bottom.
                pt_d   = (pt_q >> BITS_PER_CYC) | (slice_ext << (BLOCK_W - BITS_PER_CYC));
                ct_d   = ct_q >> BITS_PER_CYC;
                wkey_d = wkey_q >> BITS_PER_CYC;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SLICE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (pt_ready) begin
                    state_d = IDLE;
`ifdef ECB_DEC_BLKCNT_EN
                    blk_cnt_d = blk_cnt_q + 32'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        ct_ready_d = (state_d == IDLE);
        pt_valid_d = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= '0;
            wkey_q     <= '0;
            ct_q       <= '0;
            pt_q       <= '0;
            cnt_q      <= '0;
            ct_ready_q <= 1'b1;
            pt_valid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef ECB_DEC_BLKCNT_EN
            blk_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            wkey_q     <= wkey_d;
            ct_q       <= ct_d;
            pt_q       <= pt_d;
            cnt_q      <= cnt_d;
            ct_ready_q <= ct_ready_d;
            pt_valid_q <= pt_valid_d;
            busy_q     <= busy_d;
`ifdef ECB_DEC_BLKCNT_EN
            blk_cnt_q  <= blk_cnt_d;
`endif
        end
    end

    assign ct_ready = ct_ready_q;
    assign pt_data  = pt_q;
    assign pt_valid = pt_valid_q;
    assign busy     = busy_q;
`ifdef ECB_DEC_BLKCNT_EN
    assign blk_cnt  = blk_cnt_q;
`endif

endmodule

// File: tb/tb_ecb_dec_serial.sv
// Bench for ecb_dec_serial: an 8-bit/1-bit-per-clock instance for directed cases and a
// 64-bit/8-bit-per-clock instance for random round trips; covers ECB_DEC_BLKCNT_EN if set.
module tb_ecb_dec_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  a_key_in = '0, a_ct = '0, a_pt;
    logic        a_key_we = 1'b0, a_ct_valid = 1'b0, a_pt_ready = 1'b1;
    logic        a_ct_ready, a_pt_valid, a_busy;
    logic [63:0] b_key_in = '0, b_ct = '0, b_pt;
    logic        b_key_we = 1'b0, b_ct_valid = 1'b0, b_pt_ready = 1'b0;
    logic        b_ct_ready, b_pt_valid, b_busy;
`ifdef ECB_DEC_BLKCNT_EN
    logic [31:0] a_blk_cnt, b_blk_cnt;
`endif

    ecb_dec_serial #(.BLOCK_W(8), .BITS_PER_CYC(1)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (a_key_in),
        .key_we   (a_key_we),
        .ct_data  (a_ct),
        .ct_valid (a_ct_valid),
        .ct_ready (a_ct_ready),
        .pt_data  (a_pt),
        .pt_valid (a_pt_valid),
        .pt_ready (a_pt_ready),
        .busy     (a_busy)
`ifdef ECB_DEC_BLKCNT_EN
        ,
        .blk_cnt  (a_blk_cnt)
`endif
    );

    ecb_dec_serial #(.BLOCK_W(64), .BITS_PER_CYC(8)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (b_key_in),
        .key_we   (b_key_we),
        .ct_data  (b_ct),
        .ct_valid (b_ct_valid),
        .ct_ready (b_ct_ready),
        .pt_data  (b_pt),
        .pt_valid (b_pt_valid),
        .pt_ready (b_pt_ready),
        .busy     (b_busy)
`ifdef ECB_DEC_BLKCNT_EN
        ,
        .blk_cnt  (b_blk_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_wkey(input logic [7:0] k);
        a_key_in = k;
        a_key_we = 1'b1;
        tick();
        a_key_we = 1'b0;
    endtask

    // Presents one block for one edge; any key_we the caller set rides along.
    task automatic a_send(input logic [7:0] ct);
        chk("a_ready_before_send", a_ct_ready, 1);
        a_ct       = ct;
        a_ct_valid = 1'b1;
        tick();
        a_ct_valid = 1'b0;
        a_key_we   = 1'b0;
    endtask

    // Returns the plaintext and the cycle index (accept cycle = 0) where pt_valid appeared.
    task automatic a_wait(output logic [7:0] pt, output int cyc);
        cyc = 1;
        while (!a_pt_valid && cyc < 64) begin
            tick();
            cyc++;
        end
        if (!a_pt_valid) chk("a_pt_valid_timeout", 0, 1);
        pt = a_pt;
        tick();
    endtask

    logic [7:0]  pt8;
    int          cyc;
    int          seen;
    logic [63:0] key_model, snap, pt_orig, nk;
    bit          stable;

    initial begin
        // 1: reset values
        #3;
        chk("rst_pt_valid", a_pt_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_pt_data", a_pt, 0);
        chk("rst_b_pt_data", b_pt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ct_ready", a_ct_ready, 1);
        tick();

        // 2: latency and ready spacing
        a_wkey(8'hA5);
        a_send(8'h3C);
        chk("shift_busy", a_busy, 1);
        chk("shift_ct_ready", a_ct_ready, 0);
        cyc = 1;
        while (!a_pt_valid && cyc < 64) begin
            tick();
            cyc++;
        end
        chk("lat_cycle", cyc, 9);
        chk("lat_pt_data", a_pt, 8'h99);
        chk("done_ct_ready", a_ct_ready, 0);
        tick();
        chk("ready_back_cycle10", a_ct_ready, 1);
        chk("idle_pt_valid", a_pt_valid, 0);

        // 4: key write timing
        a_wkey(8'h0F);
        a_send(8'h00);
        a_key_in = 8'hFF;
        a_key_we = 1'b1;
        tick();
        a_key_we = 1'b0;
        a_wait(pt8, cyc);
        chk("inflight_keeps_snapshot", pt8, 8'h0F);
        a_send(8'h00);
        a_wait(pt8, cyc);
        chk("next_block_new_key", pt8, 8'hFF);
        a_wkey(8'h0F);
        a_key_in = 8'hFF;
        a_key_we = 1'b1;
        a_send(8'h00);
        a_wait(pt8, cyc);
        chk("same_cycle_write_through", pt8, 8'hFF);
        a_send(8'hC3);
        a_wait(pt8, cyc);
        chk("ct_c3_key_ff", pt8, 8'h3C);

        // 5: reset in the middle of SHIFT
        a_wkey(8'h5A);
        a_send(8'h3C);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        chk("midrst_busy", a_busy, 0);
        chk("midrst_pt_valid", a_pt_valid, 0);
        chk("midrst_pt_data", a_pt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_pt_valid) seen++;
        end
        chk("midrst_no_pt_valid", seen, 0);
        a_send(8'h77);
        a_wait(pt8, cyc);
        chk("after_rst_key0", pt8, 8'h77);

        // 3: random round trips with backpressure and key traffic
        key_model = '0;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(3) == 0) begin
                nk = {$urandom, $urandom};
                b_key_in = nk;
                b_key_we = 1'b1;
                tick();
                b_key_we = 1'b0;
                key_model = nk;
            end
            if ($urandom_range(7) == 0) begin
                nk = {$urandom, $urandom};
                b_key_in = nk;
                b_key_we = 1'b1;
                key_model = nk;
            end
            snap = key_model;
            pt_orig = {$urandom, $urandom};
            b_ct = pt_orig ^ snap;
            b_ct_valid = 1'b1;
            b_pt_ready = 1'b0;
            tick();
            b_ct_valid = 1'b0;
            b_key_we = 1'b0;
            if ($urandom_range(3) == 0) begin
                nk = {$urandom, $urandom};
                b_key_in = nk;
                b_key_we = 1'b1;
                tick();
                b_key_we = 1'b0;
                key_model = nk;
            end
            cyc = 0;
            while (!b_pt_valid && cyc < 40) begin
                tick();
                cyc++;
            end
            if (!b_pt_valid) chk("b_pt_valid_timeout", 0, 1);
            chk("rt_pt_data", b_pt, pt_orig);
            stable = 1'b1;
            for (int s = $urandom_range(3); s > 0; s--) begin
                tick();
                if (!b_pt_valid || b_pt !== pt_orig) stable = 1'b0;
            end
            chk("rt_stall_stable", stable, 1);
            b_pt_ready = 1'b1;
            tick();
            b_pt_ready = 1'b0;
            chk("rt_back_idle", b_ct_ready, 1);
        end

`ifdef ECB_DEC_BLKCNT_EN
        // 6: completed-block counter
        rst_n = 1'b0;
        #2;
        chk("cnt_rst", a_blk_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            a_send(8'(i));
            a_wait(pt8, cyc);
        end
        chk("cnt_three", a_blk_cnt, 3);
        force dut_a.blk_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut_a.blk_cnt_q;
        chk("cnt_preload", a_blk_cnt, 32'hFFFF_FFFF);
        a_send(8'h11);
        a_wait(pt8, cyc);
        chk("cnt_wrap", a_blk_cnt, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
